// File: rtl/reaction_match_game.sv
// Reaction game: two digits cycle on each tick, and players race to press while they match.
// Wrong-press lockout is compiled in only when RMG_LOCKOUT_EN is defined.
module reaction_match_game #(
  parameter int NUM_PLAYERS   = 2,
  parameter int DIGIT_W       = 4,
  parameter int DIGIT_MAX     = 9,
  parameter int SCORE_W       = 4,
  parameter int POINTS_TO_WIN = 3,
  parameter int RESULT_TICKS  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           tick,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         btn_n,
  output logic [DIGIT_W-1:0]             digit_a,
  output logic [DIGIT_W-1:0]             digit_b,
  output logic                           match,
  output logic [NUM_PLAYERS-1:0]         round_winner,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS-1:0]         lockout,
  output logic                           game_over,
  output logic [NUM_PLAYERS-1:0]         champion,
  output logic [1:0]                     state
);

  localparam int IDX_W = $clog2(NUM_PLAYERS);
  localparam int CNT_W = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;
  localparam logic [DIGIT_W:0]   MODULUS   = (DIGIT_W+1)'(DIGIT_MAX + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(POINTS_TO_WIN);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(RESULT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [DIGIT_W-1:0]     digit_a_reg, digit_a_next, digit_b_reg, digit_b_next;
  logic [DIGIT_W-1:0]     inc_a_reg, inc_a_next, inc_b_reg, inc_b_next;
  logic [SCORE_W-1:0]     score_reg  [NUM_PLAYERS];
  logic [SCORE_W-1:0]     score_next [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] round_winner_reg, round_winner_next;
  logic [NUM_PLAYERS-1:0] lockout_reg, lockout_next;
  logic [NUM_PLAYERS-1:0] champion_reg, champion_next;
  logic [NUM_PLAYERS-1:0] btn_hist_reg;
  logic                   game_over_reg, game_over_next;
  logic [CNT_W-1:0]       res_cnt_reg, res_cnt_next;

  logic [NUM_PLAYERS-1:0] press, eligible, win_flag;
  logic                   sel_valid, any_win;
  logic [IDX_W-1:0]       sel_idx, champ_idx;

  function automatic logic [DIGIT_W-1:0] mod_add(input logic [DIGIT_W-1:0] x,
                                                 input logic [DIGIT_W-1:0] y);
    logic [DIGIT_W:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= MODULUS) sum = sum - MODULUS;
    return sum[DIGIT_W-1:0];
  endfunction

  // A press is a 1->0 transition against the previous sample.
  assign press    = btn_hist_reg & ~btn_n;
  assign eligible = press & ~lockout_reg;
  assign match    = (digit_a_reg == digit_b_reg);

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      assign win_flag[gi]                   = (score_reg[gi] >= WIN_SCORE);
      assign score[gi*SCORE_W +: SCORE_W]   = score_reg[gi];
    end
  endgenerate
  assign any_win = |win_flag;

  // Lowest-index eligible presser wins arbitration; strict > keeps lowest index on score ties.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    champ_idx = '0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (score_reg[i] > score_reg[champ_idx]) champ_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_next        = state_reg;
    digit_a_next      = digit_a_reg;
    digit_b_next      = digit_b_reg;
    inc_a_next        = inc_a_reg;
    inc_b_next        = inc_b_reg;
    score_next        = score_reg;
    round_winner_next = round_winner_reg;
    lockout_next      = lockout_reg;
    champion_next     = champion_reg;
    game_over_next    = game_over_reg;
    res_cnt_next      = res_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (tick) begin
          digit_a_next = mod_add(digit_a_reg, inc_a_reg);
          digit_b_next = mod_add(digit_b_reg, inc_b_reg);
          inc_a_next   = mod_add(inc_a_reg, DIGIT_W'(1));
          inc_b_next   = mod_add(inc_b_reg, DIGIT_W'(1));
        end
        if (sel_valid && match) begin
          if (score_reg[sel_idx] != SCORE_MAX) score_next[sel_idx] = score_reg[sel_idx] + 1'b1;
          round_winner_next          = '0;
          round_winner_next[sel_idx] = 1'b1;
          res_cnt_next               = '0;
          state_next                 = ST_RESULT;
        end
`ifdef RMG_LOCKOUT_EN
        else if (sel_valid) begin
          lockout_next[sel_idx] = 1'b1;
        end
        if (&lockout_reg) begin
          round_winner_next = '0;
          res_cnt_next      = '0;
          state_next        = ST_RESULT;
        end
`endif
      end
      ST_RESULT: begin
        if (tick) begin
          if (res_cnt_reg == CNT_LAST) begin
            res_cnt_next = '0;
            lockout_next = '0;
            if (any_win) begin
              state_next               = ST_DONE;
              game_over_next           = 1'b1;
              champion_next            = '0;
              champion_next[champ_idx] = 1'b1;
            end else begin
              state_next = ST_RUN;
            end
          end else begin
            res_cnt_next = res_cnt_reg + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          for (int i = 0; i < NUM_PLAYERS; i++) score_next[i] = '0;
          round_winner_next = '0;
          champion_next     = '0;
          game_over_next    = 1'b0;
          state_next        = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase

`ifdef RMG_LOCKOUT_EN
`else
    lockout_next = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      state_reg        <= ST_IDLE;
      digit_a_reg      <= DIGIT_W'(2);
      digit_b_reg      <= DIGIT_W'(3);
      inc_a_reg        <= DIGIT_W'(2);
      inc_b_reg        <= DIGIT_W'(3);
      for (int i = 0; i < NUM_PLAYERS; i++) score_reg[i] <= '0;
      round_winner_reg <= '0;
      lockout_reg      <= '0;
      champion_reg     <= '0;
      game_over_reg    <= 1'b0;
      res_cnt_reg      <= '0;
      btn_hist_reg     <= '1;
    end else begin
      state_reg        <= state_next;
      digit_a_reg      <= digit_a_next;
      digit_b_reg      <= digit_b_next;
      inc_a_reg        <= inc_a_next;
      inc_b_reg        <= inc_b_next;
      score_reg        <= score_next;
      round_winner_reg <= round_winner_next;
      lockout_reg      <= lockout_next;
      champion_reg     <= champion_next;
      game_over_reg    <= game_over_next;
      res_cnt_reg      <= res_cnt_next;
      btn_hist_reg     <= btn_n;
    end
  end

  assign digit_a      = digit_a_reg;
  assign digit_b      = digit_b_reg;
  assign round_winner = round_winner_reg;
  assign lockout      = lockout_reg;
  assign game_over    = game_over_reg;
  assign champion     = champion_reg;
  assign state        = state_reg;

endmodule

// File: tb/tb_reaction_match_game.sv
// Directed, table-driven bench for reaction_match_game with default parameters.
module tb_reaction_match_game;

  logic       clk = 1'b0;
  logic       rst, en, tick, start;
  logic [1:0] btn_n;
  logic [3:0] digit_a, digit_b;
  logic       match;
  logic [1:0] round_winner;
  logic [7:0] score;
  logic [1:0] lockout;
  logic       game_over;
  logic [1:0] champion;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  reaction_match_game dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .start(start), .btn_n(btn_n),
    .digit_a(digit_a), .digit_b(digit_b), .match(match), .round_winner(round_winner),
    .score(score), .lockout(lockout), .game_over(game_over), .champion(champion),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       s;
    logic       t;
    logic [1:0] b;
    logic [1:0] st;
    logic [3:0] a;
    logic [3:0] bb;
    logic       m;
    logic [7:0] sc;
    logic [1:0] rw;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic t, input logic s, input logic [1:0] b);
    @(negedge clk);
    tick  = t;
    start = s;
    btn_n = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_digit_a"}, digit_a, 2);
    chk({tag, "_digit_b"}, digit_b, 3);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_round_winner"}, round_winner, 0);
    chk({tag, "_lockout"}, lockout, 0);
    chk({tag, "_champion"}, champion, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_match"}, match, 0);
  endtask

  // From IDLE with reset digits: start, 9 ticks to (6,6), player 1 wins, two result ticks.
  task automatic run_to_mid_result();
    step(1'b0, 1'b1, 2'b11);
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 2'b11);
    step(1'b0, 1'b0, 2'b01);
    chk("mid_enter_state", state, 2);
    chk("mid_enter_score", score, 8'h10);
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b11);
    chk("mid_result_state", state, 2);
  endtask

  task automatic result_ticks();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          s     t     b      st     a  bb  m     score  rw
    vecs[0]  = '{1'b1, 1'b0, 2'b11, 2'd1, 4'd2, 4'd3, 1'b0, 8'h00, 2'b00};
    vecs[1]  = '{1'b0, 1'b1, 2'b11, 2'd1, 4'd4, 4'd6, 1'b0, 8'h00, 2'b00};
    vecs[2]  = '{1'b0, 1'b1, 2'b11, 2'd1, 4'd7, 4'd0, 1'b0, 8'h00, 2'b00};
    vecs[3]  = '{1'b0, 1'b1, 2'b11, 2'd1, 4'd1, 4'd5, 1'b0, 8'h00, 2'b00};
    vecs[4]  = '{1'b0, 1'b1, 2'b11, 2'd1, 4'd6, 4'd1, 1'b0, 8'h00, 2'b00};
    vecs[5]  = '{1'b0, 1'b1, 2'b11, 2'd1, 4'd2, 4'd8, 1'b0, 8'h00, 2'b00};
    vecs[6]  = '{1'b0, 1'b1, 2'b11, 2'd1, 4'd9, 4'd6, 1'b0, 8'h00, 2'b00};
    vecs[7]  = '{1'b0, 1'b1, 2'b11, 2'd1, 4'd7, 4'd5, 1'b0, 8'h00, 2'b00};
    vecs[8]  = '{1'b0, 1'b1, 2'b11, 2'd1, 4'd6, 4'd5, 1'b0, 8'h00, 2'b00};
    vecs[9]  = '{1'b0, 1'b1, 2'b11, 2'd1, 4'd6, 4'd6, 1'b1, 8'h00, 2'b00};
    vecs[10] = '{1'b0, 1'b0, 2'b01, 2'd2, 4'd6, 4'd6, 1'b1, 8'h10, 2'b10};
    vecs[11] = '{1'b0, 1'b1, 2'b11, 2'd2, 4'd6, 4'd6, 1'b1, 8'h10, 2'b10};
    vecs[12] = '{1'b0, 1'b1, 2'b11, 2'd2, 4'd6, 4'd6, 1'b1, 8'h10, 2'b10};
    vecs[13] = '{1'b0, 1'b1, 2'b11, 2'd2, 4'd6, 4'd6, 1'b1, 8'h10, 2'b10};
    vecs[14] = '{1'b0, 1'b1, 2'b11, 2'd1, 4'd6, 4'd6, 1'b1, 8'h10, 2'b10};
    vecs[15] = '{1'b0, 1'b0, 2'b00, 2'd2, 4'd6, 4'd6, 1'b1, 8'h11, 2'b01};

    rst = 1'b0; en = 1'b1; tick = 1'b0; start = 1'b0; btn_n = 2'b11;
    step(1'b0, 1'b0, 2'b11);
    step(1'b0, 1'b0, 2'b11);
    chk_reset_values("reset");
    rst = 1'b1;

    // Presses in IDLE do nothing.
    step(1'b0, 1'b0, 2'b10);
    chk("idle_press_state", state, 0);
    chk("idle_press_score", score, 0);
    step(1'b0, 1'b0, 2'b11);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].t, vecs[i].s, vecs[i].b);
      $display("vec %0d: state=%0d digits=(%0d,%0d) match=%0d score=%h rw=%b",
               i, state, digit_a, digit_b, match, score, round_winner);
      chk($sformatf("vec%0d_state", i), state, vecs[i].st);
      chk($sformatf("vec%0d_digit_a", i), digit_a, vecs[i].a);
      chk($sformatf("vec%0d_digit_b", i), digit_b, vecs[i].bb);
      chk($sformatf("vec%0d_match", i), match, vecs[i].m);
      chk($sformatf("vec%0d_score", i), score, vecs[i].sc);
      chk($sformatf("vec%0d_round_winner", i), round_winner, vecs[i].rw);
    end

    // Result window boundary: still RESULT after 3 ticks, RUN after the 4th.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 2'b11);
    chk("result_3ticks_state", state, 2);
    step(1'b1, 1'b0, 2'b11);
    chk("result_4ticks_state", state, 1);

    // Player 0 wins twice more to reach 3 points.
    step(1'b0, 1'b0, 2'b10);
    $display("win2: state=%0d score=%h", state, score);
    chk("win2_score", score, 8'h12);
    result_ticks();
    chk("win2_back_run", state, 1);
    step(1'b0, 1'b0, 2'b10);
    $display("win3: state=%0d score=%h", state, score);
    chk("win3_score", score, 8'h13);
    chk("win3_rw", round_winner, 2'b01);
    result_ticks();
    $display("done: state=%0d game_over=%0d champion=%b", state, game_over, champion);
    chk("done_state", state, 3);
    chk("done_game_over", game_over, 1);
    chk("done_champion", champion, 2'b01);

    step(1'b0, 1'b0, 2'b10);
    chk("done_press_ignored_score", score, 8'h13);
    chk("done_press_ignored_state", state, 3);
    step(1'b0, 1'b0, 2'b11);

    step(1'b0, 1'b1, 2'b11);
    $display("restart: state=%0d score=%h digits=(%0d,%0d)", state, score, digit_a, digit_b);
    chk("restart_state", state, 1);
    chk("restart_score", score, 0);
    chk("restart_rw", round_winner, 0);
    chk("restart_champion", champion, 0);
    chk("restart_game_over", game_over, 0);
    chk("restart_digit_a", digit_a, 6);
    chk("restart_digit_b", digit_b, 6);

    // One tick from (6,6) with increments (1,2) gives (7,8): no match.
    step(1'b1, 1'b0, 2'b11);
    chk("nomatch_digit_a", digit_a, 7);
    chk("nomatch_digit_b", digit_b, 8);
    chk("nomatch_match", match, 0);

    step(1'b0, 1'b0, 2'b10);
    $display("wrong press p0: state=%0d lockout=%b score=%h", state, lockout, score);
    chk("wrong_press_state", state, 1);
    chk("wrong_press_score", score, 0);
`ifdef RMG_LOCKOUT_EN
    chk("wrong_press_lockout", lockout, 2'b01);
    step(1'b0, 1'b0, 2'b11);
    step(1'b0, 1'b0, 2'b01);
    chk("both_locked_lockout", lockout, 2'b11);
    step(1'b0, 1'b0, 2'b11);
    chk("all_locked_state", state, 2);
    chk("all_locked_rw", round_winner, 0);
    result_ticks();
    chk("lock_round_end_state", state, 1);
    chk("lock_round_end_lockout", lockout, 0);
`else
    chk("wrong_press_lockout", lockout, 0);
    step(1'b0, 1'b0, 2'b11);
    step(1'b0, 1'b0, 2'b01);
    chk("wrong_press2_state", state, 1);
    chk("wrong_press2_lockout", lockout, 0);
    chk("wrong_press2_rw", round_winner, 0);
`endif

    // Reset and enable-low abort a game mid-RESULT.
    rst = 1'b0;
    step(1'b0, 1'b0, 2'b11);
    rst = 1'b1;
    chk_reset_values("rst_idle");
    run_to_mid_result();
    rst = 1'b0;
    step(1'b1, 1'b0, 2'b11);
    $display("rst mid-result: state=%0d score=%h digits=(%0d,%0d)", state, score, digit_a, digit_b);
    chk_reset_values("rst_mid");
    rst = 1'b1;

    run_to_mid_result();
    en = 1'b0;
    step(1'b1, 1'b0, 2'b11);
    $display("en low mid-result: state=%0d score=%h digits=(%0d,%0d)", state, score, digit_a, digit_b);
    chk_reset_values("en_mid");
    en = 1'b1;
    step(1'b1, 1'b0, 2'b11);
    chk("after_en_state", state, 0);
    chk("after_en_score", score, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
